// File: rtl/acondicionador_entradas_pkg.sv
// Shared definitions for the input conditioning block: button FSM states
// and default timing parameters (cycles at 100 MHz).
package acondicionador_entradas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } btn_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int REPEAT_DELAY_DEF    = 50000000;
  localparam int REPEAT_PERIOD_DEF   = 20000000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/acondicionador_entradas_filtro_rebote.sv
// One input channel: 2-flop synchronizer followed by a stability counter that
// flips the debounced level after DEBOUNCE_CYCLES consecutive differing samples.
module filtro_rebote
  import acondicionador_entradas_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q, sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flip;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= raw_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // rise/fall announce the level change on the same edge that commits it,
  // so downstream registers line up with the new level.
  always_comb begin
    flip    = (sync_q != level_q) && (cnt_q == CNT_LAST);
    level_d = flip ? ~level_q : level_q;
    cnt_d   = ((sync_q == level_q) || flip) ? '0 : cnt_q + 1'b1;
  end

  assign level_o = level_q;
  assign rise_o  = flip & ~level_q;
  assign fall_o  = flip & level_q;

endmodule

// File: rtl/acondicionador_entradas.sv
// Conditions the board pushbuttons and slide switches: debounced switch levels
// plus single-cycle press pulses with auto-repeat on the up/down buttons.
module acondicionador_entradas
  import acondicionador_entradas_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_arriba,
  input  logic btn_abajo,
  input  logic btn_izquierda,
  input  logic btn_derecha,
  input  logic sw_escribe,
  input  logic sw_crono,
  input  logic sw_reset,
  input  logic sw_cr_activo,
  output logic push_arriba,
  output logic push_abajo,
  output logic push_izquierda,
  output logic push_derecha,
  output logic escribe1,
  output logic crono1,
  output logic reset1,
  output logic cr_activo1
);

  localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [7:0]    rawIn, levelAll, riseAll, fallAll;
  logic [11:0]   unusedBits;
  btn_state_e    state_q [4];
  logic [RW-1:0] rcnt_q  [4];
  logic [3:0]    want, push_q, push_d;

  // Channels 0..3 are buttons (up, down, left, right), 4..7 are switches.
  assign rawIn = {sw_cr_activo, sw_reset, sw_crono, sw_escribe,
                  btn_derecha, btn_izquierda, btn_abajo, btn_arriba};

  for (genvar k = 0; k < 8; k++) begin : g_canal
    filtro_rebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filtro (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (rawIn[k]),
      .level_o(levelAll[k]),
      .rise_o (riseAll[k]),
      .fall_o (fallAll[k])
    );
  end

  assign unusedBits = {levelAll[3:0], riseAll[7:4], fallAll[7:4]};

  // A release always wins over a pending repeat; up+down coincident pulses cancel.
  always_comb begin
    want = '0;
    for (int i = 0; i < 4; i++) begin
      if (!fallAll[i]) begin
        case (state_q[i])
          IDLE:    want[i] = riseAll[i];
          PRESSED: want[i] = (i < 2) && (rcnt_q[i] == DELAY_LAST);
          REPEAT:  want[i] = (rcnt_q[i] == PERIOD_LAST);
          default: want[i] = 1'b0;
        endcase
      end
    end
    push_d = want & ~{2'b00, want[0] & want[1], want[0] & want[1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push_q <= '0;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= IDLE;
        rcnt_q[i]  <= '0;
      end
    end else begin
      push_q <= push_d;
      for (int i = 0; i < 4; i++) begin
        if (fallAll[i]) begin
          state_q[i] <= IDLE;
          rcnt_q[i]  <= '0;
        end else begin
          case (state_q[i])
            IDLE: begin
              if (riseAll[i]) begin
                state_q[i] <= PRESSED;
                rcnt_q[i]  <= '0;
              end
            end
            PRESSED: begin
              if (i < 2) begin
                if (rcnt_q[i] == DELAY_LAST) begin
                  state_q[i] <= REPEAT;
                  rcnt_q[i]  <= '0;
                end else begin
                  rcnt_q[i] <= rcnt_q[i] + 1'b1;
                end
              end
            end
            REPEAT: begin
              if (rcnt_q[i] == PERIOD_LAST) rcnt_q[i] <= '0;
              else                          rcnt_q[i] <= rcnt_q[i] + 1'b1;
            end
            default: begin
              state_q[i] <= IDLE;
              rcnt_q[i]  <= '0;
            end
          endcase
        end
      end
    end
  end

  assign push_arriba    = push_q[0];
  assign push_abajo     = push_q[1];
  assign push_izquierda = push_q[2];
  assign push_derecha   = push_q[3];
  assign escribe1       = levelAll[4];
  assign crono1         = levelAll[5];
  assign reset1         = levelAll[6];
  assign cr_activo1     = levelAll[7];

endmodule

// File: tb/tb_acondicionador_entradas.sv
// Directed bench: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// Inputs change on the falling edge; pulse cycles are logged against a posedge counter.
module tb_acondicionador_entradas;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_arriba = 1'b0, btn_abajo = 1'b0, btn_izquierda = 1'b0, btn_derecha = 1'b0;
  logic sw_escribe = 1'b0, sw_crono = 1'b0, sw_reset = 1'b0, sw_cr_activo = 1'b0;
  logic push_arriba, push_abajo, push_izquierda, push_derecha;
  logic escribe1, crono1, reset1, cr_activo1;
  logic [7:0] allOut;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pArriba[$], pAbajo[$], pIzq[$], pDer[$];
  int expv[6];
  int c, r;
  logic early;

  acondicionador_entradas #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_arriba    (btn_arriba),
    .btn_abajo     (btn_abajo),
    .btn_izquierda (btn_izquierda),
    .btn_derecha   (btn_derecha),
    .sw_escribe    (sw_escribe),
    .sw_crono      (sw_crono),
    .sw_reset      (sw_reset),
    .sw_cr_activo  (sw_cr_activo),
    .push_arriba   (push_arriba),
    .push_abajo    (push_abajo),
    .push_izquierda(push_izquierda),
    .push_derecha  (push_derecha),
    .escribe1      (escribe1),
    .crono1        (crono1),
    .reset1        (reset1),
    .cr_activo1    (cr_activo1)
  );

  assign allOut = {cr_activo1, reset1, crono1, escribe1,
                   push_derecha, push_izquierda, push_abajo, push_arriba};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (push_arriba)    pArriba.push_back(cyc);
    if (push_abajo)     pAbajo.push_back(cyc);
    if (push_izquierda) pIzq.push_back(cyc);
    if (push_derecha)   pDer.push_back(cyc);
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int which, input logic val);
    case (which)
      0: btn_arriba    = val;
      1: btn_abajo     = val;
      2: btn_izquierda = val;
      3: btn_derecha   = val;
      4: sw_escribe    = val;
      5: sw_crono      = val;
      6: sw_reset      = val;
      default: sw_cr_activo = val;
    endcase
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearPulses();
    pArriba.delete();
    pAbajo.delete();
    pIzq.delete();
    pDer.delete();
  endtask

  function automatic int pulseCount(input int idx);
    case (idx)
      0: return pArriba.size();
      1: return pAbajo.size();
      2: return pIzq.size();
      default: return pDer.size();
    endcase
  endfunction

  function automatic int pulseAt(input int idx, input int k);
    if (k >= pulseCount(idx)) return -1;
    case (idx)
      0: return pArriba[k];
      1: return pAbajo[k];
      2: return pIzq[k];
      default: return pDer[k];
    endcase
  endfunction

  task automatic checkPulseList(input string tag, input int idx, input int expT[6], input int n);
    checkOutput({tag, "_count"}, pulseCount(idx), n);
    for (int k = 0; k < n; k++)
      checkOutput($sformatf("%s_t%0d", tag, k), pulseAt(idx, k), expT[k]);
  endtask

  initial begin
    waitCycles(3);
    checkOutput("reset_outputs", int'(allOut), 0);
    reset = 1'b1;
    waitCycles(10);

    // Left button held 100 cycles: a single pulse, never repeats.
    clearPulses();
    c = cyc;
    applyStimulus(2, 1'b1);
    waitCycles(5);
    checkOutput("izq_before_threshold", int'(push_izquierda), 0);
    waitCycles(95);
    applyStimulus(2, 1'b0);
    waitCycles(20);
    expv = '{c + 6, 0, 0, 0, 0, 0};
    checkPulseList("izq", 2, expv, 1);

    // Right button held 40 cycles: also no auto-repeat.
    clearPulses();
    c = cyc;
    applyStimulus(3, 1'b1);
    waitCycles(40);
    applyStimulus(3, 1'b0);
    waitCycles(20);
    expv = '{c + 6, 0, 0, 0, 0, 0};
    checkPulseList("der", 3, expv, 1);

    // Up button: 3-cycle glitch is rejected, then a 60-cycle hold repeats.
    clearPulses();
    applyStimulus(0, 1'b1);
    waitCycles(3);
    applyStimulus(0, 1'b0);
    waitCycles(15);
    checkOutput("arriba_glitch_count", pulseCount(0), 0);
    c = cyc;
    applyStimulus(0, 1'b1);
    waitCycles(60);
    applyStimulus(0, 1'b0);
    waitCycles(20);
    expv = '{c + 6, c + 26, c + 34, c + 42, c + 50, c + 58};
    checkPulseList("arriba_hold", 0, expv, 6);

    // Chattering switch must not move crono1 until it settles.
    c = cyc;
    early = 1'b0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(5, (k % 2) == 0);
      waitCycles(1);
      early = early | crono1;
      waitCycles(1);
      early = early | crono1;
    end
    applyStimulus(5, 1'b1);
    waitCycles(5);
    checkOutput("crono_chatter", int'(early | crono1), 0);
    waitCycles(1);
    checkOutput("crono_settle_cycle", cyc - c, 26);
    checkOutput("crono_rise", int'(crono1), 1);

    // Up and down pressed together: every pulse coincides and is dropped.
    clearPulses();
    applyStimulus(0, 1'b1);
    applyStimulus(1, 1'b1);
    waitCycles(40);
    applyStimulus(0, 1'b0);
    applyStimulus(1, 1'b0);
    waitCycles(20);
    checkOutput("both_arriba_count", pulseCount(0), 0);
    checkOutput("both_abajo_count", pulseCount(1), 0);

    // Down held across a reset pulse: fresh press after release.
    clearPulses();
    c = cyc;
    applyStimulus(1, 1'b1);
    waitCycles(15);
    reset = 1'b0;
    waitCycles(1);
    checkOutput("midreset_outputs_a", int'(allOut), 0);
    waitCycles(1);
    checkOutput("midreset_outputs_b", int'(allOut), 0);
    r = cyc;
    reset = 1'b1;
    waitCycles(40);
    applyStimulus(1, 1'b0);
    waitCycles(20);
    expv = '{c + 6, r + 6, r + 26, r + 34, r + 42, 0};
    checkPulseList("abajo_reset", 1, expv, 5);

    // All switches high across reset release.
    reset = 1'b0;
    for (int k = 4; k < 8; k++) applyStimulus(k, 1'b1);
    waitCycles(3);
    clearPulses();
    r = cyc;
    reset = 1'b1;
    waitCycles(5);
    checkOutput("sw_before_rise", int'(allOut[7:4]), 0);
    waitCycles(1);
    checkOutput("sw_rise", int'(allOut[7:4]), 15);
    waitCycles(10);
    checkOutput("sw_no_push", pulseCount(0) + pulseCount(1) + pulseCount(2) + pulseCount(3), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
